delay_seq_gen: RTL and testbench

Stimulus generator that produces the `a`-then-`b` event pattern checked by the delay-operator cover properties (`a ##1 b`, `a ##N b`). Each accepted request produces a one-cycle pulse on `a`, then a one-cycle pulse on `b` exactly `delay` cycles later. It sits in the same default-clocked environment as the property modules and drives their `a`/`b` signals, so every cover property can be hit deterministically.

---
 rtl/delay_seq_pkg.sv | 13 +
 rtl/delay_seq_gen.sv | 102 ++++++++++
 tb/tb_delay_seq_gen.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/delay_seq_pkg.sv
// Shared types and constants for the a-then-b delay sequence generator.
package delay_seq_pkg;

  localparam int DEFAULT_MAX_DELAY = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    A    = 2'd1,
    WAIT = 2'd2,
    B    = 2'd3
  } state_e;

endpackage

// File: rtl/delay_seq_gen.sv
// Emits a one-cycle pulse on a, then a one-cycle pulse on b exactly delay cycles later.
//
// state | meaning
// IDLE  | no sequence in flight
// A     | a is high
// WAIT  | counting down between a and b
// B     | b and done are high; a new request may be accepted here
module delay_seq_gen
  import delay_seq_pkg::*;
#(
  parameter int MAX_DELAY = DEFAULT_MAX_DELAY,
  parameter int DELAY_W   = $clog2(MAX_DELAY + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DELAY_W-1:0] delay,
  output logic               ready,
  output logic               a,
  output logic               b,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_e             state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic               a_q, b_q, busy_q, err_q;
  logic               delay_ok;
  logic               accept;
  logic               err_d;

  assign ready    = (state_q == IDLE) || (state_q == B);
  assign delay_ok = (delay != '0) && (delay <= DELAY_W'(MAX_DELAY));
  assign accept   = start && ready && delay_ok;
  // Covers both bad-value and busy rejects; one pulse per rejected cycle.
  assign err_d    = start && !accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    delay_d = delay_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = A;
          delay_d = delay;
        end
      end
      A: begin
        if (delay_q == DELAY_W'(1)) begin
          state_d = B;
        end else begin
          state_d = WAIT;
          cnt_d   = delay_q - DELAY_W'(2);
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = B;
        else             cnt_d   = cnt_q - DELAY_W'(1);
      end
      B: begin
        if (accept) begin
          state_d = A;
          delay_d = delay;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      delay_q <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
      a_q     <= (state_d == A);
      b_q     <= (state_d == B);
      busy_q  <= (state_d != IDLE);
      err_q   <= err_d;
    end
  end

  assign a    = a_q;
  assign b    = b_q;
  assign done = b_q;
  assign busy = busy_q;
  assign err  = err_q;

endmodule

// File: tb/tb_delay_seq_gen.sv
// Bench for delay_seq_gen: two instances (MAX_DELAY 7 and 5) checked against a timeline model.
module tb_delay_seq_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] delay;
  logic [1:0] ready_o, a_o, b_o, busy_o, done_o, err_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: each instance remembers the cycle of its pending a and b pulses and of its next err.
  int maxd[2];
  int a_cyc[2];
  int b_cyc[2];
  int err_cyc[2];

  delay_seq_gen #(.MAX_DELAY(7)) dut (
    .clk(clk), .rst(rst), .start(start), .delay(delay),
    .ready(ready_o[0]), .a(a_o[0]), .b(b_o[0]), .busy(busy_o[0]),
    .done(done_o[0]), .err(err_o[0])
  );

  // Narrower legal range on the same 3-bit port exercises the delay > MAX_DELAY reject.
  delay_seq_gen #(.MAX_DELAY(5)) dut_m5 (
    .clk(clk), .rst(rst), .start(start), .delay(delay),
    .ready(ready_o[1]), .a(a_o[1]), .b(b_o[1]), .busy(busy_o[1]),
    .done(done_o[1]), .err(err_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      a_cyc[i]   = -10;
      b_cyc[i]   = -10;
      err_cyc[i] = -10;
    end
  endtask

  function automatic bit model_ready(input int i);
    return !(a_cyc[i] <= cyc && cyc < b_cyc[i]);
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ready%0d", i), 32'(ready_o[i]), 32'(model_ready(i)));
      chk($sformatf("a%0d", i),     32'(a_o[i]),     32'(cyc == a_cyc[i]));
      chk($sformatf("b%0d", i),     32'(b_o[i]),     32'(cyc == b_cyc[i]));
      chk($sformatf("done%0d", i),  32'(done_o[i]),  32'(cyc == b_cyc[i]));
      chk($sformatf("busy%0d", i),  32'(busy_o[i]),  32'(a_cyc[i] <= cyc && cyc <= b_cyc[i]));
      chk($sformatf("err%0d", i),   32'(err_o[i]),   32'(cyc == err_cyc[i]));
      chk($sformatf("a_and_b%0d", i), 32'(a_o[i] & b_o[i]), 32'(0));
    end
  endtask

  // Called just after a negedge: check this cycle, drive the request, advance one clock.
  task automatic step(input bit s, input int d);
    check_outputs();
    start = s;
    delay = 3'(d);
    for (int i = 0; i < 2; i++) begin
      if (s) begin
        if (model_ready(i) && d >= 1 && d <= maxd[i]) begin
          a_cyc[i] = cyc + 1;
          b_cyc[i] = cyc + 1 + d;
        end else begin
          err_cyc[i] = cyc + 1;
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    start = 1'b0;
    delay = '0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    cyc++;
    rst = 1'b0;
  endtask

  initial begin
    maxd[0] = 7;
    maxd[1] = 5;
    model_reset();
    rst   = 1'b1;
    start = 1'b0;
    delay = '0;
    #12;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // delay 1: a then b on the very next cycle
    step(1'b1, 1); idle(3);
    // delay 3
    step(1'b1, 3); idle(5);
    // delay 2 then back-to-back delay 1 requested in the b cycle
    step(1'b1, 2); idle(2); step(1'b1, 1); idle(3);
    // zero delay rejected twice in a row
    step(1'b1, 0); step(1'b1, 0); idle(2);
    // 6 is legal for MAX 7 but rejected by the MAX 5 instance
    step(1'b1, 6); idle(8);
    // max delay with a busy reject during WAIT
    step(1'b1, 7); idle(3); step(1'b1, 2); idle(6);
    // reset in the middle of WAIT, then a normal request
    step(1'b1, 5); idle(2); pulse_reset();
    step(1'b1, 1); idle(3);

    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 79) == 0) pulse_reset();
      else step($urandom_range(0, 2) == 0, int'($urandom_range(0, 7)));
    end
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
